rv_mc_ctrl: RTL and testbench

Multicycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback over the shared datapath (IR, PC, regfile, ALU, immediate generator, single memory port). Decodes the opcode latched in DECODE and drives the datapath selects and write strobes. Also counts retired instructions.

---
 rtl/rv_mc_ctrl_if.sv | 50 +++++
 rtl/rv_mc_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rv_mc_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mc_ctrl_if.sv
// Control/handshake bundle between the multicycle RV32I controller and its datapath.
// RV_MC_CTRL_MEM_TIMEOUT_EN adds the sticky bus_err output.
interface rv_mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [31:0]      insn;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic [1:0]       alu_a_sel;
  logic             alu_b_sel;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instret;
`ifdef RV_MC_CTRL_MEM_TIMEOUT_EN
  logic             bus_err;

  modport master (
    input  start, insn, branch_taken, mem_ready,
    output mem_req, mem_we, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel,
           rf_we, wb_sel, state, halted, illegal, instret, bus_err
  );

  modport slave (
    output start, insn, branch_taken, mem_ready,
    input  mem_req, mem_we, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel,
           rf_we, wb_sel, state, halted, illegal, instret, bus_err
  );
`else
  modport master (
    input  start, insn, branch_taken, mem_ready,
    output mem_req, mem_we, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel,
           rf_we, wb_sel, state, halted, illegal, instret
  );

  modport slave (
    output start, insn, branch_taken, mem_ready,
    input  mem_req, mem_we, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel,
           rf_we, wb_sel, state, halted, illegal, instret
  );
`endif
endinterface

// File: rtl/rv_mc_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing and instret counting.
// Optional memory-wait timeout with sticky bus_err when RV_MC_CTRL_MEM_TIMEOUT_EN is defined.
module rv_mc_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic          clk,
  input logic          rst_n,
  rv_mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic opc_legal(input logic [6:0] opc);
    logic ok;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM: ok = 1'b1;
      default:                                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Returns {alu_a_sel, alu_b_sel} for a latched opcode.
  function automatic logic [2:0] alu_sel(input logic [6:0] opc);
    logic [2:0] sel;
    case (opc)
      OPC_LUI:                                     sel = {2'd2, 1'b1};
      OPC_AUIPC, OPC_JAL:                          sel = {2'd1, 1'b1};
      OPC_JALR, OPC_LOAD, OPC_STORE, OPC_OPIMM:    sel = {2'd0, 1'b1};
      OPC_OP, OPC_BRANCH:                          sel = {2'd0, 1'b0};
      default:                                     sel = {2'd0, 1'b0};
    endcase
    return sel;
  endfunction

  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       mem_req_s;
  logic       mem_we_s;
  logic       ir_we_s;
  logic       pc_we_s;
  logic [1:0] pc_src_s;
  logic [1:0] alu_a_sel_s;
  logic       alu_b_sel_s;
  logic       rf_we_s;
  logic [1:0] wb_sel_s;
  logic       halted_s;
  logic       timeout_s;

  logic [24:0] unused_insn_s;
  assign unused_insn_s = bus.insn[31:7];

`ifdef RV_MC_CTRL_MEM_TIMEOUT_EN
  localparam int             WCW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           bus_err_q, bus_err_d;

  // Timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT.
  assign timeout_s = !bus.mem_ready && (wait_cnt_q == WAIT_LAST);
`else
  localparam int unused_mem_timeout = MEM_TIMEOUT;
  assign timeout_s = 1'b0;
`endif

  // Next-state, sequencing side effects and datapath control decode.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    illegal_d   = illegal_q;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    ir_we_s     = 1'b0;
    pc_we_s     = 1'b0;
    pc_src_s    = 2'd0;
    alu_a_sel_s = 2'd0;
    alu_b_sel_s = 1'b0;
    rf_we_s     = 1'b0;
    wb_sel_s    = 2'd0;
    halted_s    = 1'b0;
`ifdef RV_MC_CTRL_MEM_TIMEOUT_EN
    bus_err_d   = bus_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        mem_req_s = 1'b1;
        if (bus.mem_ready) begin
          ir_we_s = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_HALT;
`ifdef RV_MC_CTRL_MEM_TIMEOUT_EN
          bus_err_d = 1'b1;
`endif
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECODE: begin
        opcode_d = bus.insn[6:0];
        if (bus.insn[6:0] == OPC_SYSTEM) begin
          state_d = S_HALT;
        end else if (!opc_legal(bus.insn[6:0])) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        {alu_a_sel_s, alu_b_sel_s} = alu_sel(opcode_q);
        case (opcode_q)
          OPC_BRANCH: begin
            pc_we_s  = 1'b1;
            pc_src_s = bus.branch_taken ? 2'd1 : 2'd0;
            state_d  = S_FETCH;
          end
          OPC_LOAD, OPC_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end

      S_MEM: begin
        {alu_a_sel_s, alu_b_sel_s} = alu_sel(opcode_q);
        mem_req_s = 1'b1;
        mem_we_s  = (opcode_q == OPC_STORE);
        if (bus.mem_ready) begin
          if (opcode_q == OPC_STORE) begin
            pc_we_s = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_s) begin
          state_d = S_HALT;
`ifdef RV_MC_CTRL_MEM_TIMEOUT_EN
          bus_err_d = 1'b1;
`endif
        end else begin
          state_d = S_MEM;
        end
      end

      S_WB: begin
        {alu_a_sel_s, alu_b_sel_s} = alu_sel(opcode_q);
        rf_we_s = 1'b1;
        pc_we_s = 1'b1;
        case (opcode_q)
          OPC_LOAD:           wb_sel_s = 2'd1;
          OPC_JAL, OPC_JALR:  wb_sel_s = 2'd2;
          default:            wb_sel_s = 2'd0;
        endcase
        case (opcode_q)
          OPC_JAL:  pc_src_s = 2'd1;
          OPC_JALR: pc_src_s = 2'd2;
          default:  pc_src_s = 2'd0;
        endcase
        state_d = S_FETCH;
      end

      S_HALT: begin
        halted_s = 1'b1;
        state_d  = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An instruction retires on the edge that commits its PC update.
    if (pc_we_s) begin
      instret_d = instret_q + CNT_W'(1);
    end else begin
      instret_d = instret_q;
    end

`ifdef RV_MC_CTRL_MEM_TIMEOUT_EN
    // Non-request states hold the count at zero, so every FETCH/MEM entry starts clean.
    if (mem_req_s && !bus.mem_ready) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end else begin
      wait_cnt_d = {WCW{1'b0}};
    end
`endif
  end

  // State, latched opcode, sticky flags and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      opcode_q   <= 7'd0;
      illegal_q  <= 1'b0;
      instret_q  <= {CNT_W{1'b0}};
`ifdef RV_MC_CTRL_MEM_TIMEOUT_EN
      wait_cnt_q <= {WCW{1'b0}};
      bus_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      illegal_q  <= illegal_d;
      instret_q  <= instret_d;
`ifdef RV_MC_CTRL_MEM_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.ir_we     = ir_we_s;
  assign bus.pc_we     = pc_we_s;
  assign bus.pc_src    = pc_src_s;
  assign bus.alu_a_sel = alu_a_sel_s;
  assign bus.alu_b_sel = alu_b_sel_s;
  assign bus.rf_we     = rf_we_s;
  assign bus.wb_sel    = wb_sel_s;
  assign bus.state     = state_q;
  assign bus.halted    = halted_s;
  assign bus.illegal   = illegal_q;
  assign bus.instret   = instret_q;
`ifdef RV_MC_CTRL_MEM_TIMEOUT_EN
  assign bus.bus_err   = bus_err_q;
`endif

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Self-checking bench for rv_mc_ctrl: directed vector table, randomized instruction
// stream against a transaction-level reference, and reset/halt corner sequences.
module tb_rv_mc_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv_mc_ctrl_if #(.CNT_W(32)) bus ();

  rv_mc_ctrl #(.MEM_TIMEOUT(255), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_OP     = 7'b0110011;

  // One instruction: stimulus plus expected transaction-level outcome.
  typedef struct {
    logic [31:0] insn;
    logic        bt;
    int          fw;     // fetch wait cycles
    int          mw;     // data-access wait cycles
    int          lat;    // cycles from first FETCH cycle to retire cycle inclusive
    int          nreq;   // cycles with mem_req high
    logic [1:0]  a;
    logic        b;
    logic [1:0]  wb;
    logic [1:0]  pcs;
    logic        rf;
    logic        store;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_instret = 32'd0;
  int          trace_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: outcome of one instruction from the opcode-level rules.
  function automatic vec_t ref_model(input logic [31:0] insn, input logic bt,
                                     input int fw, input int mw);
    vec_t r;
    int   base;
    bit   is_mem;
    r.insn = insn; r.bt = bt; r.fw = fw; r.mw = mw;
    r.a = 2'd0; r.b = 1'b1; r.wb = 2'd0; r.pcs = 2'd0; r.rf = 1'b1; r.store = 1'b0;
    base = 4; is_mem = 1'b0;
    case (insn[6:0])
      T_LUI:    r.a = 2'd2;
      T_AUIPC:  r.a = 2'd1;
      T_JAL:    begin r.a = 2'd1; r.wb = 2'd2; r.pcs = 2'd1; end
      T_JALR:   begin r.wb = 2'd2; r.pcs = 2'd2; end
      T_BRANCH: begin base = 3; r.b = 1'b0; r.rf = 1'b0; r.pcs = bt ? 2'd1 : 2'd0; end
      T_LOAD:   begin base = 5; is_mem = 1'b1; r.wb = 2'd1; end
      T_STORE:  begin is_mem = 1'b1; r.store = 1'b1; r.rf = 1'b0; end
      T_OP:     r.b = 1'b0;
      default:  ;
    endcase
    r.lat  = base + fw + (is_mem ? mw : 0);
    r.nreq = 1 + fw + (is_mem ? 1 + mw : 0);
    return r;
  endfunction

  // Runs one instruction starting at a FETCH negedge; memory stalls per v.fw / v.mw.
  task automatic run_insn(input string tag, input vec_t v);
    int   cyc, nreq, fleft, mleft;
    bit   data_phase, retired, we_seen, we_bad;
    logic [1:0] c_a, c_wb, c_pcs;
    logic c_b, c_rf;
    cyc = 0; nreq = 0; fleft = v.fw; mleft = v.mw;
    data_phase = 1'b0; retired = 1'b0; we_seen = 1'b0; we_bad = 1'b0;
    c_a = 2'd0; c_wb = 2'd0; c_pcs = 2'd0; c_b = 1'b0; c_rf = 1'b0;
    trace_q.delete();
    chk({tag, "_start_state"}, bus.state, 3'd1);
    bus.insn = v.insn;
    bus.branch_taken = v.bt;
    while (!retired && cyc < 64) begin
      trace_q.push_back(int'(bus.state));
      if (bus.mem_req) begin
        nreq++;
        if (data_phase ? (mleft > 0) : (fleft > 0)) begin
          bus.mem_ready = 1'b0;
          if (data_phase) mleft--; else fleft--;
        end else begin
          bus.mem_ready = 1'b1;
        end
      end else begin
        bus.mem_ready = 1'b0;
      end
      #1;
      if (bus.mem_we) begin
        we_seen = 1'b1;
        if (!(data_phase && v.store)) we_bad = 1'b1;
      end
      if (bus.ir_we) data_phase = 1'b1;
      if (bus.pc_we) begin
        retired = 1'b1;
        c_a = bus.alu_a_sel; c_b = bus.alu_b_sel; c_wb = bus.wb_sel;
        c_pcs = bus.pc_src; c_rf = bus.rf_we;
      end
      cyc++;
      @(negedge clk);
    end
    if (!retired) begin
      chk({tag, "_retire_timeout"}, 1'b0, 1'b1);
    end else begin
      exp_instret = exp_instret + 32'd1;
      chk({tag, "_latency"}, cyc, v.lat);
      chk({tag, "_mem_req_cycles"}, nreq, v.nreq);
      chk({tag, "_alu_a"}, c_a, v.a);
      chk({tag, "_alu_b"}, c_b, v.b);
      chk({tag, "_wb_sel"}, c_wb, v.wb);
      chk({tag, "_pc_src"}, c_pcs, v.pcs);
      chk({tag, "_rf_we"}, c_rf, v.rf);
      chk({tag, "_mem_we"}, {we_seen, we_bad}, {v.store, 1'b0});
      chk({tag, "_next_state"}, bus.state, 3'd1);
      chk({tag, "_instret"}, bus.instret, exp_instret);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (bus.state !== s && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach_state"}, bus.state, s);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  vec_t        tbl[11];
  logic [6:0]  ops[9];
  int          exp_tr[4];

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //                insn          bt    fw mw lat nreq a     b     wb    pcs   rf    store
    tbl[0]  = '{32'h00500093, 1'b0, 0, 0, 4, 1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0}; // addi
    tbl[1]  = '{32'h0000A103, 1'b0, 0, 3, 8, 5, 2'd0, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0}; // lw, 3 waits
    tbl[2]  = '{32'h00000463, 1'b1, 0, 0, 3, 1, 2'd0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0}; // beq taken
    tbl[3]  = '{32'h00000463, 1'b0, 0, 0, 3, 1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // beq not taken
    tbl[4]  = '{32'h123450B7, 1'b0, 0, 0, 4, 1, 2'd2, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0}; // lui
    tbl[5]  = '{32'h00001097, 1'b0, 0, 0, 4, 1, 2'd1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0}; // auipc
    tbl[6]  = '{32'h008000EF, 1'b0, 0, 0, 4, 1, 2'd1, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0}; // jal
    tbl[7]  = '{32'h000080E7, 1'b0, 0, 0, 4, 1, 2'd0, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0}; // jalr
    tbl[8]  = '{32'h00112023, 1'b0, 2, 1, 7, 5, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1}; // sw, waits
    tbl[9]  = '{32'h002081B3, 1'b0, 1, 0, 5, 2, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0}; // add, fetch wait
    tbl[10] = '{32'h0000A103, 1'b0, 2, 0, 7, 4, 2'd0, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0}; // lw, fetch waits
    ops = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH, T_LOAD, T_STORE, T_OPIMM, T_OP};
    exp_tr = '{1, 2, 3, 5};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.insn = 32'd0; bus.branch_taken = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", bus.state, 3'd0);
    chk("reset_strobes", {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.rf_we}, 5'd0);
    chk("reset_flags", {bus.halted, bus.illegal}, 2'd0);
    chk("reset_instret", bus.instret, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", bus.state, 3'd0);
    pulse_start();
    chk("start_to_fetch", bus.state, 3'd1);

    for (int i = 0; i < 11; i++) begin
      run_insn($sformatf("vec%0d", i), tbl[i]);
      if (i == 0) begin
        chk("addi_trace_len", trace_q.size(), 4);
        for (int k = 0; k < 4 && k < trace_q.size(); k++)
          chk($sformatf("addi_trace%0d", k), trace_q[k], exp_tr[k]);
      end
    end

    for (int i = 0; i < 40; i++) begin
      logic [31:0] r32;
      logic        bt;
      int          fw, mw;
      r32 = $urandom();
      bt  = 1'($urandom_range(1, 0));
      fw  = $urandom_range(3, 0);
      mw  = $urandom_range(3, 0);
      r32 = {r32[31:7], ops[$urandom_range(8, 0)]};
      run_insn($sformatf("rnd%0d", i), ref_model(r32, bt, fw, mw));
    end

    // Reset mid-store: outputs collapse the moment rst_n falls.
    bus.insn = 32'h00112023;
    bus.mem_ready = 1'b1;
    wait_state(3'd4, "store_mem");
    bus.mem_ready = 1'b0;
    #1;
    chk("store_mem_req_we", {bus.mem_req, bus.mem_we}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", bus.state, 3'd0);
    chk("midrst_strobes", {bus.mem_req, bus.mem_we, bus.pc_we, bus.rf_we}, 4'd0);
    chk("midrst_instret", bus.instret, 32'd0);
    chk("midrst_illegal", bus.illegal, 1'b0);
    exp_instret = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SYSTEM halts without flagging illegal.
    pulse_start();
    bus.insn = 32'h00000073;
    bus.mem_ready = 1'b1;
    wait_state(3'd6, "system");
    chk("system_flags", {bus.halted, bus.illegal}, 2'b10);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Illegal opcode: sticky flag, absorbing HALT that ignores start.
    pulse_start();
    bus.insn = 32'hFFFFFFFF;
    wait_state(3'd6, "illegal");
    chk("illegal_flags", {bus.halted, bus.illegal}, 2'b11);
    begin
      bit escaped;
      escaped = 1'b0;
      bus.start = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (bus.mem_req || bus.state != 3'd6 || !bus.illegal) escaped = 1'b1;
      end
      bus.start = 1'b0;
      chk("halt_absorbing", escaped, 1'b0);
    end
    chk("halt_instret", bus.instret, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
